decode_regread_stage: RTL and testbench
=======================================

DECODE_REGREAD_STAGE -- requirements
Module: decode_regread_stage

Interface
REQ-001 SHALL provide parameter N, default 16, datapath and instruction width.
REQ-002 SHALL provide parameter NREG, default 8, number of architectural registers (3-bit index).
REQ-003 SHALL provide port clk, input, 1, sole clock, all state updates on rising edge.
REQ-004 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide port instr_valid, input, 1, fetch presents an instruction.
REQ-006 SHALL provide port instr, input, N, fields: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored.
REQ-007 SHALL provide port instr_ready, output, 1, stage accepts instr this cycle.
REQ-008 SHALL provide port wb_en, input, 1, writeback strobe.
REQ-009 SHALL provide port wb_addr, input, 3, writeback register index.
REQ-010 SHALL provide port wb_data, input, N, writeback value.
REQ-011 SHALL provide port out_valid, output, 1, issued operand bundle valid.
REQ-012 SHALL provide port out_ready, input, 1, execute stage consumes bundle.
REQ-013 SHALL provide port opcode, output, 4, registered opcode for the rs1 operand mux.
REQ-014 SHALL provide port rs1_data, output, N, registered rs1 operand.
REQ-015 SHALL provide port rs2_data, output, N, registered rs2 operand.
REQ-016 SHALL provide port rd_addr, output, 3, registered destination index.
REQ-017 SHALL provide port illegal, output, 1, registered flag, opcode outside 4'b0000..4'b0100.

Function
REQ-018 SHALL hold an NREG x N register file; r0 reads 0 always, writes to r0 ignored.
REQ-019 SHALL hold one busy bit per register; r0 never busy.
REQ-020 SHALL compute busy_eff[i] = busy[i] & ~(wb_en & wb_addr==i), used for all hazard checks.
REQ-021 SHALL detect hazard when busy_eff is set for rs1, rs2 or rd of a legal instr; illegal instr checks no hazard.
REQ-022 SHALL drive instr_ready = (~out_valid | out_ready) & ~hazard, combinationally.
REQ-023 SHALL accept (fire) when instr_valid & instr_ready; on fire, load output registers next edge and set out_valid.
REQ-024 SHALL set out_valid low next edge when out_ready & out_valid & no fire; hold all outputs stable while out_valid & ~out_ready.
REQ-025 SHALL forward wb_data to rs1_data/rs2_data when wb_en and wb_addr equals the source index (nonzero) in the fire cycle.
REQ-026 SHALL write wb_data to register file on wb_en (wb_addr != 0) and clear busy[wb_addr] same edge.
REQ-027 SHALL on fire of a legal instr with rd != 0 set busy[rd] next edge; set takes priority over a same-cycle clear of that index.
REQ-028 SHALL for illegal instr pass opcode through, set illegal=1, drive rs1_data=rs2_data=0, not set any busy bit.
REQ-029 SHALL provide latency of 1 cycle from fire to out_valid; throughput 1 per cycle absent hazard/backpressure.
REQ-030 SHALL ignore instr contents when instr_valid=0; no state change except writeback.

Reset
REQ-031 SHALL on rst_n low asynchronously clear out_valid, illegal, opcode, rd_addr, rs1_data, rs2_data, all busy bits and all register-file entries to 0.
REQ-032 SHALL discard any in-flight bundle on reset mid-operation; first fire permitted on first rising edge after rst_n high.

Verification
REQ-033 SHALL cover: wb r1=0x1234, r2=0x0011; instr 0x0288 (op 0, rd1, rs1=2, rs2=1) -> next cycle out_valid=1, opcode=0, rs1_data=0x0011, rs2_data=0x1234, rd_addr=1.
REQ-034 SHALL cover: issue op 1 rd=3, then instr reading r3 -> instr_ready=0 until wb_en r3=0xBEEF; same cycle instr fires with rs1_data=0xBEEF forwarded.
REQ-035 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, instr_ready=0; out_ready=1 -> back-to-back fire accepted.
REQ-036 SHALL cover: instr opcode 4'b1010 -> illegal=1, rs1_data=0, rs2_data=0, no busy set, next legal instr issues without stall.
REQ-037 SHALL cover: wb to r0 with 0xFFFF, then read r0 -> rs1_data=0; rst_n pulse while out_valid=1 -> out_valid=0 and busy cleared immediately.

Source files
------------

// File: rtl/decode_regread_stage.sv
// Decode / register-read stage: register file with per-register busy scoreboard,
// writeback forwarding, hazard stall and a single registered operand bundle.
module decode_regread_stage #(
  parameter int N    = 16,
  parameter int NREG = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  input  logic [N-1:0] instr,
  output logic         instr_ready,
  input  logic         wb_en,
  input  logic [2:0]   wb_addr,
  input  logic [N-1:0] wb_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   opcode,
  output logic [N-1:0] rs1_data,
  output logic [N-1:0] rs2_data,
  output logic [2:0]   rd_addr,
  output logic         illegal
);

  logic [N-1:0]    r_rf [NREG];
  logic [NREG-1:0] r_busy;
  logic            r_out_valid;
  logic            r_illegal;
  logic [3:0]      r_opcode;
  logic [2:0]      r_rd_addr;
  logic [N-1:0]    r_rs1_data;
  logic [N-1:0]    r_rs2_data;

  logic [3:0]      w_op;
  logic [2:0]      w_rd;
  logic [2:0]      w_rs1;
  logic [2:0]      w_rs2;
  logic            w_legal;
  logic            w_hazard;
  logic            w_fire;
  logic [NREG-1:0] w_wb_hit;
  logic [NREG-1:0] w_busy_eff;
  logic [NREG-1:0] w_busy_set;
  logic [NREG-1:0] w_busy_next;
  logic [N-1:0]    w_rs1_val;
  logic [N-1:0]    w_rs2_val;
  logic            w_unused_bits;

  assign w_op          = instr[15:12];
  assign w_rd          = instr[11:9];
  assign w_rs1         = instr[8:6];
  assign w_rs2         = instr[5:3];
  assign w_unused_bits = ^instr[2:0];
  assign w_legal       = (w_op <= 4'd4);

  // One-hot of the register being written back this cycle; r0 never matches.
  always_comb begin
    w_wb_hit = '0;
    for (int i = 1; i < NREG; i++) begin
      if (wb_en && (wb_addr == 3'(i))) begin
        w_wb_hit[i] = 1'b1;
      end
    end
  end

  assign w_busy_eff = r_busy & ~w_wb_hit;

  assign w_hazard = w_legal &
                    (w_busy_eff[w_rs1] | w_busy_eff[w_rs2] | w_busy_eff[w_rd]);

  assign instr_ready = (~r_out_valid | out_ready) & ~w_hazard;
  assign w_fire      = instr_valid & instr_ready;

  always_comb begin
    w_rs1_val = '0;
    if (w_rs1 != 3'd0) begin
      if (wb_en && (wb_addr == w_rs1)) begin
        w_rs1_val = wb_data;
      end else begin
        w_rs1_val = r_rf[w_rs1];
      end
    end
  end

  always_comb begin
    w_rs2_val = '0;
    if (w_rs2 != 3'd0) begin
      if (wb_en && (wb_addr == w_rs2)) begin
        w_rs2_val = wb_data;
      end else begin
        w_rs2_val = r_rf[w_rs2];
      end
    end
  end

  always_comb begin
    w_busy_set = '0;
    if (w_fire && w_legal && (w_rd != 3'd0)) begin
      w_busy_set[w_rd] = 1'b1;
    end
  end

  // Issue sets override a same-edge writeback clear; bit 0 is pinned low.
  assign w_busy_next = ((r_busy & ~w_wb_hit) | w_busy_set) &
                       {{(NREG-1){1'b1}}, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else if (wb_en && (wb_addr != 3'd0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_opcode    <= '0;
      r_rd_addr   <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_illegal   <= ~w_legal;
      r_opcode    <= w_op;
      r_rd_addr   <= w_rd;
      r_rs1_data  <= w_legal ? w_rs1_val : '0;
      r_rs2_data  <= w_legal ? w_rs2_val : '0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign illegal   = r_illegal;
  assign opcode    = r_opcode;
  assign rd_addr   = r_rd_addr;
  assign rs1_data  = r_rs1_data;
  assign rs2_data  = r_rs2_data;

endmodule

// File: tb/tb_decode_regread_stage.sv
// Bench for decode_regread_stage: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the stage.
module tb_decode_regread_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  opcode;
  logic [15:0] rs1_data;
  logic [15:0] rs2_data;
  logic [2:0]  rd_addr;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  decode_regread_stage #(.N(16), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_rf [8];
  bit          m_busy [8];
  bit          m_valid, m_ill, m_ready, m_fire;
  logic [3:0]  m_op;
  logic [2:0]  m_rd;
  logic [15:0] m_rs1, m_rs2;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_rf[i] = '0; m_busy[i] = 0; end
    m_valid = 0; m_ill = 0; m_op = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
  endtask

  function automatic bit eff_busy(int x);
    return m_busy[x] && !(wb_en && int'(wb_addr) == x);
  endfunction

  function automatic logic [15:0] src_val(int x);
    if (x == 0) return 16'h0;
    if (wb_en && int'(wb_addr) == x) return wb_data;
    return m_rf[x];
  endfunction

  task automatic eval();
    int rd, s1, s2;
    bit legal, haz;
    rd = int'(instr[11:9]); s1 = int'(instr[8:6]); s2 = int'(instr[5:3]);
    legal = instr[15:12] <= 4'd4;
    haz = legal && (eff_busy(s1) || eff_busy(s2) || eff_busy(rd));
    m_ready = (!m_valid || out_ready) && !haz;
    m_fire = instr_valid && m_ready;
  endtask

  task automatic set_in(input bit iv, input logic [15:0] ins, input bit ordy,
                        input bit wbe, input logic [2:0] wba, input logic [15:0] wbd);
    instr_valid = iv; instr = ins; out_ready = ordy;
    wb_en = wbe; wb_addr = wba; wb_data = wbd;
    eval();
    #1;
  endtask

  task automatic advance();
    int rd;
    bit legal;
    logic [15:0] v1, v2;
    eval();
    rd = int'(instr[11:9]);
    legal = instr[15:12] <= 4'd4;
    v1 = src_val(int'(instr[8:6]));
    v2 = src_val(int'(instr[5:3]));
    @(posedge clk);
    if (m_fire) begin
      m_valid = 1; m_op = instr[15:12]; m_ill = !legal; m_rd = instr[11:9];
      m_rs1 = legal ? v1 : 16'h0; m_rs2 = legal ? v2 : 16'h0;
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (wb_en && wb_addr != 3'd0) begin
      m_rf[wb_addr] = wb_data; m_busy[wb_addr] = 0;
    end
    if (m_fire && legal && rd != 0) m_busy[rd] = 1;
    #1;
  endtask

  task automatic drain();
    for (int i = 1; i < 8; i++) begin
      if (m_busy[i]) begin
        set_in(0, 16'h0, 1, 1, 3'(i), m_rf[i]);
        advance();
      end
    end
    set_in(0, 16'h0, 1, 0, 3'd0, 16'h0);
    advance();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %0h exp 0", out_valid); end
    n_cmp++; if ({illegal, opcode, rd_addr} !== 8'h0) begin n_bad++; $display("FAIL rst_ctrl got %0h exp 0", {illegal, opcode, rd_addr}); end
    n_cmp++; if ({rs1_data, rs2_data} !== 32'h0) begin n_bad++; $display("FAIL rst_data got %0h exp 0", {rs1_data, rs2_data}); end
    instr_valid = 1'b1; instr = 16'h0000; out_ready = 1'b1;
    #1 rst_n = 1'b1;
    eval();
    #1;
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_first_ready got %0h exp 1", instr_ready); end
    advance();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_first_fire got %0h exp 1", out_valid); end
    set_in(0, 16'h0, 1, 0, 3'd0, 16'h0);
    advance();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_drop_valid got %0h exp 0", out_valid); end
  endtask

  task automatic test_basic_read();
    set_in(0, 16'h0, 1, 1, 3'd1, 16'h1234); advance();
    set_in(0, 16'h0, 1, 1, 3'd2, 16'h0011); advance();
    set_in(1, 16'h0288, 1, 0, 3'd0, 16'h0);
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready got %0h exp 1", instr_ready); end
    advance();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %0h exp 1", out_valid); end
    n_cmp++; if (opcode !== 4'h0) begin n_bad++; $display("FAIL basic_opcode got %0h exp 0", opcode); end
    n_cmp++; if (rs1_data !== 16'h0011) begin n_bad++; $display("FAIL basic_rs1 got %0h exp 0011", rs1_data); end
    n_cmp++; if (rs2_data !== 16'h1234) begin n_bad++; $display("FAIL basic_rs2 got %0h exp 1234", rs2_data); end
    n_cmp++; if (rd_addr !== 3'd1) begin n_bad++; $display("FAIL basic_rd got %0h exp 1", rd_addr); end
    set_in(0, 16'h0, 1, 0, 3'd0, 16'h0); advance();
    drain();
  endtask

  task automatic test_hazard_forward();
    set_in(1, 16'h1600, 1, 0, 3'd0, 16'h0);
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL haz_issue_ready got %0h exp 1", instr_ready); end
    advance();
    n_cmp++; if (opcode !== 4'h1 || rd_addr !== 3'd3) begin n_bad++; $display("FAIL haz_issue got %0h/%0h exp 1/3", opcode, rd_addr); end
    for (int k = 0; k < 2; k++) begin
      set_in(1, 16'h08C0, 1, 0, 3'd0, 16'h0);
      n_cmp++; if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL haz_stall cyc %0d got %0h exp 0", k, instr_ready); end
      advance();
    end
    set_in(1, 16'h08C0, 1, 1, 3'd3, 16'hBEEF);
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL haz_release got %0h exp 1", instr_ready); end
    advance();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL haz_fwd_valid got %0h exp 1", out_valid); end
    n_cmp++; if (rs1_data !== 16'hBEEF) begin n_bad++; $display("FAIL haz_fwd_rs1 got %0h exp beef", rs1_data); end
    n_cmp++; if (rd_addr !== 3'd4) begin n_bad++; $display("FAIL haz_fwd_rd got %0h exp 4", rd_addr); end
    set_in(0, 16'h0, 1, 0, 3'd0, 16'h0); advance();
    drain();
  endtask

  task automatic test_back_to_back();
    set_in(1, 16'h2A80, 1, 0, 3'd0, 16'h0); advance();
    n_cmp++; if (opcode !== 4'h2 || rs1_data !== 16'h0011) begin n_bad++; $display("FAIL b2b_first got %0h/%0h exp 2/0011", opcode, rs1_data); end
    for (int k = 0; k < 3; k++) begin
      set_in(1, 16'h3C90, 0, 0, 3'd0, 16'h0);
      n_cmp++; if (instr_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_ready cyc %0d got %0h exp 0", k, instr_ready); end
      advance();
      n_cmp++; if ({out_valid, opcode, rd_addr, rs1_data} !== {1'b1, 4'h2, 3'd5, 16'h0011}) begin
        n_bad++; $display("FAIL b2b_hold cyc %0d got %0h exp %0h", k, {out_valid, opcode, rd_addr, rs1_data}, {1'b1, 4'h2, 3'd5, 16'h0011});
      end
    end
    set_in(1, 16'h3C90, 1, 0, 3'd0, 16'h0);
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_resume_ready got %0h exp 1", instr_ready); end
    advance();
    n_cmp++; if ({opcode, rd_addr, rs1_data, rs2_data} !== {4'h3, 3'd6, 16'h0011, 16'h0011}) begin
      n_bad++; $display("FAIL b2b_second got %0h exp %0h", {opcode, rd_addr, rs1_data, rs2_data}, {4'h3, 3'd6, 16'h0011, 16'h0011});
    end
    set_in(1, 16'h4E10, 1, 0, 3'd0, 16'h0);
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_third_ready got %0h exp 1", instr_ready); end
    advance();
    n_cmp++; if ({out_valid, opcode, rd_addr, rs2_data} !== {1'b1, 4'h4, 3'd7, 16'h0011}) begin
      n_bad++; $display("FAIL b2b_third got %0h exp %0h", {out_valid, opcode, rd_addr, rs2_data}, {1'b1, 4'h4, 3'd7, 16'h0011});
    end
    set_in(0, 16'h0, 1, 0, 3'd0, 16'h0); advance();
    drain();
  endtask

  task automatic test_illegal();
    set_in(1, 16'h0A00, 1, 0, 3'd0, 16'h0); advance();
    set_in(1, 16'hA568, 1, 0, 3'd0, 16'h0);
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL ill_no_hazard got %0h exp 1", instr_ready); end
    advance();
    n_cmp++; if ({out_valid, illegal, opcode} !== {1'b1, 1'b1, 4'hA}) begin n_bad++; $display("FAIL ill_flags got %0h exp %0h", {out_valid, illegal, opcode}, {1'b1, 1'b1, 4'hA}); end
    n_cmp++; if ({rs1_data, rs2_data} !== 32'h0) begin n_bad++; $display("FAIL ill_data got %0h exp 0", {rs1_data, rs2_data}); end
    set_in(1, 16'h0400, 1, 0, 3'd0, 16'h0);
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL ill_next_ready got %0h exp 1", instr_ready); end
    advance();
    n_cmp++; if ({illegal, opcode, rd_addr} !== {1'b0, 4'h0, 3'd2}) begin n_bad++; $display("FAIL ill_next got %0h exp %0h", {illegal, opcode, rd_addr}, {1'b0, 4'h0, 3'd2}); end
    set_in(0, 16'h0, 1, 0, 3'd0, 16'h0); advance();
    drain();
  endtask

  task automatic test_r0_and_reset();
    set_in(0, 16'h0, 1, 1, 3'd0, 16'hFFFF); advance();
    set_in(1, 16'h0000, 1, 1, 3'd0, 16'hFFFF); advance();
    n_cmp++; if ({out_valid, rs1_data, rs2_data} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL r0_read got %0h exp %0h", {out_valid, rs1_data, rs2_data}, {1'b1, 32'h0}); end
    set_in(1, 16'h0600, 1, 0, 3'd0, 16'h0); advance();
    set_in(0, 16'h0, 0, 0, 3'd0, 16'h0); advance();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid got %0h exp 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, opcode, rd_addr} !== 8'h0) begin n_bad++; $display("FAIL mid_rst_async got %0h exp 0", {out_valid, opcode, rd_addr}); end
    model_reset();
    #1 rst_n = 1'b1;
    advance();
    set_in(1, 16'h0058, 1, 0, 3'd0, 16'h0);
    n_cmp++; if (instr_ready !== 1'b1) begin n_bad++; $display("FAIL mid_busy_cleared got %0h exp 1", instr_ready); end
    advance();
    n_cmp++; if ({out_valid, rs1_data, rs2_data} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL mid_rf_cleared got %0h exp %0h", {out_valid, rs1_data, rs2_data}, {1'b1, 32'h0}); end
    set_in(0, 16'h0, 1, 0, 3'd0, 16'h0); advance();
  endtask

  task automatic test_random();
    int q[$];
    bit iv, ordy, wbe;
    logic [3:0] op;
    logic [2:0] wba;
    for (int k = 0; k < 600; k++) begin
      iv = $urandom_range(0, 9) < 7;
      ordy = $urandom_range(0, 9) < 7;
      wbe = $urandom_range(0, 9) < 4;
      op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
      q.delete();
      for (int i = 1; i < 8; i++) if (m_busy[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 9) < 7) wba = 3'(q[$urandom_range(0, q.size() - 1)]);
      else wba = 3'($urandom_range(0, 7));
      set_in(iv, {op, 12'($urandom)}, ordy, wbe, wba, 16'($urandom));
      n_cmp++; if (instr_ready !== m_ready) begin n_bad++; $display("FAIL rnd_ready cyc %0d got %0h exp %0h", k, instr_ready, m_ready); end
      advance();
      n_cmp++; if (out_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %0h exp %0h", k, out_valid, m_valid); end
      if (m_valid) begin
        n_cmp++;
        if ({illegal, opcode, rs1_data, rs2_data} !== {m_ill, m_op, m_rs1, m_rs2} || (!m_ill && rd_addr !== m_rd)) begin
          n_bad++;
          $display("FAIL rnd_bundle cyc %0d got %0h/%0h exp %0h/%0h", k, {illegal, opcode, rs1_data, rs2_data}, rd_addr, {m_ill, m_op, m_rs1, m_rs2}, m_rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_hazard_forward();
    test_back_to_back();
    test_illegal();
    test_r0_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
